prach_rd_sched: RTL and testbench
=================================

PRACH_RD_SCHED -- requirements
Module: prach_rd_sched

Interface
REQ-001 Parameter NUM_CH, default 4: number of PRACH channel buffers served, range 1..16.
REQ-002 Parameter RD_LAT, default 3: fixed channel-buffer read latency in clk cycles, from rd_en to rd_data.
REQ-003 Parameter FIFO_DEPTH, default 8: output FIFO depth in words, power of 2, at least RD_LAT+2.
REQ-004 clk  in  1  block clock, shared with the channel buffers.
REQ-005 rst_n  in  1  reset; synchronous, active-low.
REQ-006 ch_req  in  NUM_CH  per-channel request: the buffer holds a complete occasion.
REQ-007 ch_hdr  in  NUM_CH*120  per-channel C-Plane header; slice c occupies [120c+119:120c].
REQ-008 ch_num_sym  in  NUM_CH*4  per-channel symbol count of the buffered occasion.
REQ-009 ch_ack  out  NUM_CH  one-cycle acknowledge pulse to the granted channel.
REQ-010 rd_addr  out  12  word address, shared by all channel buffers.
REQ-011 rd_en  out  NUM_CH  one-hot read enable, asserted only for the granted channel.
REQ-012 rd_data  in  NUM_CH*32  per-channel read data, {di,dr}; a channel reads as zero when its rd_en is low.
REQ-013 m_valid, m_ready  out/in  1/1  output stream handshake.
REQ-014 m_data  out  32  sample {di[15:0], dr[15:0]}.
REQ-015 m_chn  out  8  channel index of the current packet.
REQ-016 m_hdr  out  120  header of the current packet, stable from the first word through the last word.
REQ-017 m_sop, m_eop  out  1/1  first-word and last-word markers, qualified by m_valid.
REQ-018 err_cnt  out  16  count of rejected occasions (see REQ-033).

Function
REQ-019 The FSM SHALL have the states IDLE, GRANT, READ and DRAIN.
REQ-020 IDLE: when any ch_req is high, the block SHALL select the first requesting channel at or after rr_ptr, wrapping around, and go to GRANT.
REQ-021 GRANT lasts one cycle and does all of the following:
 - pulses ch_ack[sel];
 - latches ch_hdr[sel] and sel;
 - computes len = 1536*ch_num_sym[sel];
 - sets rr_ptr = (sel+1) mod NUM_CH.
REQ-022 The block SHALL compute len as a 12-bit value.
REQ-023 READ SHALL issue one read (rd_en[sel]=1, rd_addr=n) per cycle, for n = 0..len-1 in order.
REQ-024 A read SHALL be issued only when fifo_count + in_flight < FIFO_DEPTH.
 - in_flight = reads issued whose data has not yet been written to the FIFO.
 - This credit rule guarantees the FIFO never overflows.
REQ-025 Read data SHALL be written to the FIFO exactly RD_LAT cycles after issue.
 - The write valid SHALL be the issue strobe delayed by RD_LAT.
 - The data SHALL be rd_data[sel] selected by the latched sel.
REQ-026 After the read with n = len-1 is issued, the FSM SHALL go to DRAIN.
REQ-027 DRAIN SHALL return to IDLE in the cycle after the m_eop word is accepted (m_valid & m_ready & m_eop).
REQ-028 The next grant SHALL therefore not occur earlier than the cycle after the previous packet's last word is accepted.
REQ-029 The FIFO SHALL be first-word-fall-through.
 - m_valid = !empty.
 - m_data SHALL hold its value while m_valid & !m_ready.
REQ-030 m_sop SHALL be 1 on word 0 of each packet.
REQ-031 m_eop SHALL be 1 on word len-1 of each packet.
REQ-032 m_hdr and m_chn SHALL update at GRANT and hold until the next GRANT.
REQ-033 If ch_num_sym[sel] is 0 or greater than 2, the occasion SHALL be rejected:
 - GRANT still pulses ch_ack;
 - no read is issued and no word is output;
 - err_cnt increments, saturating at 0xFFFF;
 - the FSM returns to IDLE.
REQ-034 If ch_req of the granted channel stays high after ch_ack, it SHALL be treated as a new request, subject to round-robin order.
REQ-035 Best-case latency SHALL be as follows:
 - ch_req to ch_ack: 2 cycles;
 - ch_ack to first m_valid: RD_LAT+1 cycles.
REQ-036 With m_ready held high, throughput SHALL be 1 word per cycle with no bubbles inside a packet.

Reset
REQ-037 While rst_n is low, the block SHALL set:
 - FSM = IDLE, rr_ptr = 0;
 - FIFO empty, in_flight = 0, read pipeline cleared;
 - ch_ack = 0, rd_en = 0, rd_addr = 0, m_valid = 0, m_sop = 0, m_eop = 0, err_cnt = 0;
 - m_hdr = 0, m_chn = 0.
REQ-038 A reset mid-packet SHALL discard all buffered and in-flight data.
 - No partial packet SHALL be output after reset.
 - The channel already acked SHALL NOT be re-acked.

Configuration
REQ-039 Macro PRACH_RD_SCHED_ERR_CNT_EN controls the error counter.
 - Defined: err_cnt behaves as in REQ-033.
 - Undefined: err_cnt is tied to 0, the counter logic is removed, and rejection behaviour is otherwise unchanged.

Verification
REQ-040 Single occasion: NUM_CH=4, ch_req[2]=1, num_sym=1, m_ready=1.
 - One ch_ack[2] pulse.
 - 1536 words with m_data[n] = buffer2[n], sop on word 0, eop on word 1535, m_chn=2.
REQ-041 Round-robin: ch_req[0] and ch_req[3] both high, rr_ptr=1.
 - Channel 3 is served first, then channel 0.
 - rr_ptr ends at 1.
REQ-042 Backpressure: num_sym=2, m_ready toggles at random at 30% duty.
 - Exactly 3072 words, in order, none dropped or duplicated.
 - FIFO never overflows.
 - m_data stable while stalled.
REQ-043 Reject: ch_num_sym=0 and then 3.
 - Two ch_ack pulses, no m_valid.
 - err_cnt=2 with the macro defined, 0 with it undefined.
REQ-044 Reset mid-READ at word 700 of channel 1.
 - After reset: m_valid=0, FSM=IDLE, no further rd_en.
 - A fresh request yields a full 1536-word packet.

Source files
------------

// File: rtl/prach_rd_sched_if.sv
// rtl/prach_rd_sched_if.sv - output sample stream bundle of prach_rd_sched
//
// master: m_valid, m_data[31:0] {di,dr}, m_chn[7:0], m_hdr[119:0], m_sop, m_eop out; m_ready in
// slave : mirror of master
interface prach_rd_sched_if;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic [7:0]   m_chn;
    logic [119:0] m_hdr;
    logic         m_sop;
    logic         m_eop;

    modport master (
        output m_valid, m_data, m_chn, m_hdr, m_sop, m_eop,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_data, m_chn, m_hdr, m_sop, m_eop,
        output m_ready
    );
endinterface

// File: rtl/prach_rd_sched.sv
// rtl/prach_rd_sched.sv - round-robin PRACH channel-buffer read scheduler with FWFT output FIFO
//
// Optional feature macro: PRACH_RD_SCHED_ERR_CNT_EN (rejected-occasion counter; err_cnt_o tied 0 if undefined)
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   ch_req_i/ch_hdr_i/ch_num_sym_i   per-channel request, 120-bit header, symbol count
//   ch_ack_o             one-cycle acknowledge to the granted channel
//   rd_addr_o/rd_en_o/rd_data_i      shared word address, one-hot read enable, per-channel read data
//   m                    output stream (prach_rd_sched_if.master)
//   err_cnt_o            saturating count of rejected occasions
module prach_rd_sched #(
    parameter int NUM_CH     = 4,
    parameter int RD_LAT     = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      ch_req_i,
    input  logic [NUM_CH*120-1:0]  ch_hdr_i,
    input  logic [NUM_CH*4-1:0]    ch_num_sym_i,
    output logic [NUM_CH-1:0]      ch_ack_o,
    output logic [11:0]            rd_addr_o,
    output logic [NUM_CH-1:0]      rd_en_o,
    input  logic [NUM_CH*32-1:0]   rd_data_i,
    prach_rd_sched_if.master       m,
    output logic [15:0]            err_cnt_o
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = 34;

    typedef enum logic [1:0] {IDLE, GRANT, READ, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d, sel_q, sel_d, pick;
    logic [PW:0]       sum;
    logic [NUM_CH-1:0] req_eff, rot;
    logic              found;
    logic [11:0]       cnt_q, cnt_d, len_q, len_d, len_now, rd_addr_q, rd_addr_d;
    logic [119:0]      hdr_q, hdr_d;
    logic [7:0]        chn_q, chn_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic              issue, iss_sop, iss_eop, bad_sym, credit, wr, pop;
    // Issue pipeline: bit 0 is the cycle rd_en is on the bus, bit RD_LAT is the FIFO write.
    logic [RD_LAT:0]   pv_q, ps_q, pe_q;
    logic [FW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [AW:0]       fcnt_q, infl_q;
    logic [FW-1:0]     head;

    logic [119:0]      hdr_a  [NUM_CH];
    logic [3:0]        nsym_a [NUM_CH];
    logic [31:0]       rdd_a  [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign hdr_a[c]  = ch_hdr_i[120*c +: 120];
        assign nsym_a[c] = ch_num_sym_i[4*c +: 4];
        assign rdd_a[c]  = rd_data_i[32*c +: 32];
    end

    // A channel whose ack is on the wire this cycle has not yet seen it, so its
    // still-high request is stale and must not win a second grant.
    always_comb begin
        req_eff = ch_req_i & ~ack_q;
        rot     = NUM_CH'({req_eff, req_eff} >> rr_q);
        found   = |rot;
        sum     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) sum = (PW+1)'(i);
        end
        sum = sum + {1'b0, rr_q};
        if (sum >= (PW+1)'(NUM_CH)) sum = sum - (PW+1)'(NUM_CH);
        pick = sum[PW-1:0];
    end

    assign len_now = 12'd1536 * {8'd0, nsym_a[sel_q]};
    assign bad_sym = (nsym_a[sel_q] == 4'd0) || (nsym_a[sel_q] > 4'd2);
    assign credit  = ({1'b0, fcnt_q} + {1'b0, infl_q}) < (AW+2)'(FIFO_DEPTH);
    assign wr      = pv_q[RD_LAT];
    assign head    = mem[rp_q];
    assign pop     = m.m_valid & m.m_ready;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rr_d      = rr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        hdr_d     = hdr_q;
        chn_d     = chn_q;
        ack_d     = '0;
        issue     = 1'b0;
        iss_sop   = 1'b0;
        iss_eop   = 1'b0;
        rd_addr_d = rd_addr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ack_d[sel_q] = 1'b1;
                hdr_d        = hdr_a[sel_q];
                chn_d        = 8'(sel_q);
                rr_d         = (sel_q == PW'(NUM_CH - 1)) ? '0 : sel_q + PW'(1);
                len_d        = len_now;
                if (bad_sym) begin
                    state_d = IDLE;
                end else begin
                    // FIFO and pipeline are empty here, so word 0 goes out with the ack.
                    issue     = 1'b1;
                    iss_sop   = 1'b1;
                    rd_addr_d = '0;
                    cnt_d     = 12'd1;
                    state_d   = READ;
                end
            end
            READ: begin
                if (credit) begin
                    issue     = 1'b1;
                    rd_addr_d = cnt_q;
                    iss_eop   = (cnt_q == len_q - 12'd1);
                    cnt_d     = cnt_q + 12'd1;
                    if (iss_eop) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && head[33]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            hdr_q     <= '0;
            chn_q     <= '0;
            ack_q     <= '0;
            rd_addr_q <= '0;
            pv_q      <= '0;
            ps_q      <= '0;
            pe_q      <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            fcnt_q    <= '0;
            infl_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            hdr_q     <= hdr_d;
            chn_q     <= chn_d;
            ack_q     <= ack_d;
            rd_addr_q <= rd_addr_d;
            pv_q      <= {pv_q[RD_LAT-1:0], issue};
            ps_q      <= {ps_q[RD_LAT-1:0], issue & iss_sop};
            pe_q      <= {pe_q[RD_LAT-1:0], issue & iss_eop};
            if (wr)  wp_q <= wp_q + AW'(1);
            if (pop) rp_q <= rp_q + AW'(1);
            fcnt_q    <= fcnt_q + (AW+1)'(wr) - (AW+1)'(pop);
            infl_q    <= infl_q + (AW+1)'(issue) - (AW+1)'(wr);
        end
    end

    // Credit accounting guarantees a free slot for every write, so no full check.
    always_ff @(posedge clk) begin
        if (wr) mem[wp_q] <= {pe_q[RD_LAT], ps_q[RD_LAT], rdd_a[sel_q]};
    end

    always_comb begin
        rd_en_o = '0;
        if (pv_q[0]) rd_en_o[sel_q] = 1'b1;
    end

    assign ch_ack_o  = ack_q;
    assign rd_addr_o = rd_addr_q;
    assign m.m_valid = (fcnt_q != '0);
    assign m.m_data  = head[31:0];
    assign m.m_sop   = m.m_valid & head[32];
    assign m.m_eop   = m.m_valid & head[33];
    assign m.m_hdr   = hdr_q;
    assign m.m_chn   = chn_q;

`ifdef PRACH_RD_SCHED_ERR_CNT_EN
    logic [15:0] err_q;
    logic        err_inc;

    assign err_inc = (state_q == GRANT) && bad_sym;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (err_inc && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt_o = err_q;
`else
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_prach_rd_sched.sv
// tb/tb_prach_rd_sched.sv - table-driven self-checking bench for prach_rd_sched
module tb_prach_rd_sched;
    localparam int NUM_CH     = 4;
    localparam int RD_LAT     = 3;
    localparam int FIFO_DEPTH = 8;
`ifdef PRACH_RD_SCHED_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_CH-1:0]     ch_req;
    logic [NUM_CH*120-1:0] ch_hdr;
    logic [NUM_CH*4-1:0]   ch_num_sym;
    logic [NUM_CH-1:0]     ch_ack;
    logic [11:0]           rd_addr;
    logic [NUM_CH-1:0]     rd_en;
    logic [NUM_CH*32-1:0]  rd_data;
    logic [15:0]           err_cnt;

    prach_rd_sched_if m_if ();

    prach_rd_sched #(.NUM_CH(NUM_CH), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_req_i     (ch_req),
        .ch_hdr_i     (ch_hdr),
        .ch_num_sym_i (ch_num_sym),
        .ch_ack_o     (ch_ack),
        .rd_addr_o    (rd_addr),
        .rd_en_o      (rd_en),
        .rd_data_i    (rd_data),
        .m            (m_if),
        .err_cnt_o    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(int c, int n);
        return {4'(c), 12'(n), 16'(n * 7 + c * 13 + 23040)};
    endfunction

    function automatic logic [119:0] hdr_val(int c);
        logic [7:0] b;
        b = 8'h30 + 8'(c);
        return {15{b}};
    endfunction

    // Channel buffer model: data for the address read in cycle t is on rd_data in cycle t+RD_LAT.
    logic [NUM_CH-1:0] en_st [RD_LAT];
    logic [11:0]       ad_st [RD_LAT];
    always @(posedge clk) begin
        en_st[0] <= rd_en;
        ad_st[0] <= rd_addr;
        for (int k = 1; k < RD_LAT; k++) begin
            en_st[k] <= en_st[k-1];
            ad_st[k] <= ad_st[k-1];
        end
    end
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en_st[RD_LAT-1][c]) rd_data[32*c +: 32] = word(c, int'(ad_st[RD_LAT-1]));
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [15:0] nsym;
        int          ready_pct;
        int          n_ack;
        int          ack0;
        int          ack1;
        int          words;
        int          errs;
        bit          chk_lat;
    } vec_t;

    vec_t vt [6];
    int   n_cmp, n_fail;

    int   cyc_n, cur_ch, cur_len, cur_n, bad, acks, words, rd_cnt, valid_cnt;
    int   ready_pct, t_ack, t_valid;
    int   ack_log [$];
    bit   active, stall_prev;
    logic [11:0] exp_addr;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_reset();
        cyc_n = 0; bad = 0; acks = 0; words = 0; rd_cnt = 0; valid_cnt = 0;
        t_ack = -1; t_valid = -1; active = 1'b0; stall_prev = 1'b0;
        cur_ch = 0; cur_len = 0; cur_n = 0; exp_addr = '0;
        ack_log.delete();
    endtask

    // One clock of stimulus and monitoring, evaluated at the falling edge.
    task automatic cyc();
        int ns;
        @(negedge clk);
        cyc_n++;
        if (ch_ack != '0) begin
            if ($countones(ch_ack) != 1) bad++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_ack[c]) begin
                    acks++;
                    ack_log.push_back(c);
                    ch_req[c] = 1'b0;
                    if (t_ack < 0) t_ack = cyc_n;
                    ns       = int'(ch_num_sym[4*c +: 4]);
                    cur_ch   = c;
                    cur_n    = 0;
                    exp_addr = '0;
                    cur_len  = (ns == 1 || ns == 2) ? 1536 * ns : 0;
                    active   = (cur_len != 0);
                end
            end
        end
        if (rd_en != '0) begin
            rd_cnt++;
            if (rd_en !== (NUM_CH'(1) << cur_ch) || rd_addr !== exp_addr) bad++;
            exp_addr++;
        end
        if (stall_prev && (!m_if.m_valid || m_if.m_data !== prev_data)) bad++;
        m_if.m_ready = ($urandom_range(99) < ready_pct);
        if (m_if.m_valid) begin
            valid_cnt++;
            if (t_valid < 0) t_valid = cyc_n;
            if (!active) begin
                bad++;
            end else if (m_if.m_ready) begin
                if (m_if.m_data !== word(cur_ch, cur_n) || m_if.m_chn !== 8'(cur_ch) ||
                    m_if.m_hdr !== hdr_val(cur_ch) || m_if.m_sop !== (cur_n == 0) ||
                    m_if.m_eop !== (cur_n == cur_len - 1)) bad++;
                words++;
                cur_n++;
                if (cur_n == cur_len) active = 1'b0;
            end
        end
        stall_prev = m_if.m_valid && !m_if.m_ready;
        prev_data  = m_if.m_data;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int budget;
        sb_reset();
        ready_pct  = v.ready_pct;
        ch_num_sym = v.nsym;
        ch_req     = v.req;
        budget     = 0;
        while (!(acks >= v.n_ack && !active) && budget < 16000) begin
            cyc();
            budget++;
        end
        if (budget >= 16000) begin
            n_cmp++; n_fail++;
            $display("FAIL v%0d_timeout: acks %0d words %0d after %0d cycles", id, acks, words, budget);
        end
        repeat (8) cyc();
        check($sformatf("v%0d_acks", id), 128'(acks), 128'(v.n_ack));
        check($sformatf("v%0d_ack0", id), 128'(ack_log.size() > 0 ? ack_log[0] : -1), 128'(v.ack0));
        if (v.n_ack > 1)
            check($sformatf("v%0d_ack1", id), 128'(ack_log.size() > 1 ? ack_log[1] : -1), 128'(v.ack1));
        check($sformatf("v%0d_words", id), 128'(words), 128'(v.words));
        check($sformatf("v%0d_reads", id), 128'(rd_cnt), 128'(v.words));
        check($sformatf("v%0d_bad_words", id), 128'(bad), 128'(0));
        check($sformatf("v%0d_err_cnt", id), 128'(err_cnt), 128'(ERR_EN ? v.errs : 0));
        if (v.chk_lat) begin
            check($sformatf("v%0d_req_to_ack", id), 128'(t_ack), 128'(2));
            check($sformatf("v%0d_ack_to_valid", id), 128'(t_valid - t_ack), 128'(RD_LAT + 1));
        end
    endtask

    initial begin
        vec_t fresh;
        int   budget;
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; ch_req = '0; ch_num_sym = '0; m_if.m_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) ch_hdr[120*c +: 120] = hdr_val(c);

        //          req      nsym     rdy% acks a0 a1 words errs lat
        vt[0] = '{4'b0100, 16'h0100, 100, 1,   2, 0, 1536, 0,   1'b1};
        vt[1] = '{4'b0001, 16'h0000, 100, 1,   0, 0, 0,    1,   1'b0};
        vt[2] = '{4'b0001, 16'h0003, 100, 1,   0, 0, 0,    2,   1'b0};
        vt[3] = '{4'b1001, 16'h1001, 100, 2,   3, 0, 3072, 2,   1'b0};
        vt[4] = '{4'b0101, 16'h0000, 100, 2,   2, 0, 0,    4,   1'b0};
        vt[5] = '{4'b0010, 16'h0020, 30,  1,   1, 0, 3072, 4,   1'b0};

        repeat (3) @(negedge clk);
        check("rst_m_valid", 128'(m_if.m_valid), 128'(0));
        check("rst_ch_ack",  128'(ch_ack),       128'(0));
        check("rst_rd_en",   128'(rd_en),        128'(0));
        check("rst_rd_addr", 128'(rd_addr),      128'(0));
        check("rst_err_cnt", 128'(err_cnt),      128'(0));
        check("rst_m_chn",   128'(m_if.m_chn),   128'(0));
        check("rst_m_hdr",   128'(m_if.m_hdr),   128'(0));
        check("rst_sop_eop", 128'({m_if.m_sop, m_if.m_eop}), 128'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Reset in the middle of a channel-1 packet.
        sb_reset();
        ready_pct  = 100;
        ch_num_sym = 16'h0010;
        ch_req     = 4'b0010;
        budget     = 0;
        while (words < 700 && budget < 3000) begin
            cyc();
            budget++;
        end
        check("mid_words_before_rst", 128'(words), 128'(700));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", 128'(m_if.m_valid), 128'(0));
        check("mid_rst_rd_en",   128'(rd_en),        128'(0));
        check("mid_rst_m_chn",   128'(m_if.m_chn),   128'(0));
        check("mid_rst_err_cnt", 128'(err_cnt),      128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        sb_reset();
        ready_pct = 100;
        repeat (20) cyc();
        check("post_rst_acks",   128'(acks),      128'(0));
        check("post_rst_valids", 128'(valid_cnt), 128'(0));
        check("post_rst_reads",  128'(rd_cnt),    128'(0));
        fresh = '{4'b0010, 16'h0010, 100, 1, 1, 0, 1536, 0, 1'b1};
        run_vec(fresh, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
